// File: rtl/aes_key_schedule_if.sv
// Bus between key-load control / round datapath and the AES key-schedule engine.
//   start, key_len, key : expansion request (key MSB-aligned)
//   busy, done, ready, err, num_rounds : engine status
//   rk_idx, rk : registered round-key read port
// master = requester / round datapath, slave = aes_key_schedule.
interface aes_key_schedule_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         ready;
  logic         err;
  logic [3:0]   num_rounds;
  logic [3:0]   rk_idx;
  logic [127:0] rk;

  modport master (
    output start, key_len, key, rk_idx,
    input  busy, done, ready, err, num_rounds, rk
  );

  modport slave (
    input  start, key_len, key, rk_idx,
    output busy, done, ready, err, num_rounds, rk
  );
endinterface

// File: rtl/aes_key_schedule.sv
// Sequential AES key-schedule engine for 128/192/256-bit keys.
// Expands one 32-bit word per cycle through a single 4-byte S-box path into a
// 60-word store, then serves round keys through a registered indexed read port.
//   clk, rst_n : clock, asynchronous active-low reset
//   ifc        : aes_key_schedule_if.slave (request, status, round-key read)
//   MAX_KEY_BITS : largest key length accepted; longer modes are rejected
//
// state  | meaning
// IDLE   | no schedule held, waiting for start
// EXPAND | generating w[Nk..T-1], one word per cycle
// READY  | schedule complete and readable
module aes_key_schedule #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic clk,
  input  logic rst_n,
  aes_key_schedule_if.slave ifc
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [5:0] nk_of(input logic [1:0] len);
    logic [5:0] n;
    n = 6'd8;
    if (len == 2'd0) n = 6'd4;
    else if (len == 2'd1) n = 6'd6;
    return n;
  endfunction

  function automatic logic key_legal(input logic [1:0] len);
    return (len != 2'b11) && ((128 + 64 * int'(len)) <= MAX_KEY_BITS);
  endfunction

  state_t       state_q, state_d;
  logic [1:0]   len_q;
  logic [5:0]   i_q;
  logic [2:0]   j_q;        // i mod Nk, maintained as a wrap counter
  logic [7:0]   rcon_q;
  logic         done_q, ready_q, err_q;
  logic [127:0] rk_q;
  logic [31:0]  w [60];

  logic         load, reject, step, fin;
  logic [5:0]   nk_q, nk_in, t_last, rd_base;
  logic [3:0]   nr_q;
  logic         j_wrap;
  logic [31:0]  prev, sub_in, sub_out, temp, w_new;
  logic [127:0] rk_word;

  assign nk_in  = nk_of(ifc.key_len);
  assign nk_q   = nk_of(len_q);
  assign nr_q   = nk_q[3:0] + 4'd6;
  // T-1 = 4*(Nr+1)-1 = 4*Nr+3
  assign t_last = {nr_q, 2'b11};
  assign j_wrap = (j_q == 3'(nk_q - 6'd1));

  // Single shared S-box path: RotWord only on the i mod Nk == 0 step.
  assign prev    = w[i_q - 6'd1];
  assign sub_in  = (j_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  assign sub_out = sub_word(sub_in);

  always_comb begin
    temp = prev;
    if (j_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 6'd8 && j_q == 3'd4)
      temp = sub_out;
  end

  assign w_new   = w[i_q - nk_q] ^ temp;
  assign rd_base = {ifc.rk_idx, 2'b00};
  assign rk_word = {w[rd_base], w[rd_base | 6'd1], w[rd_base | 6'd2], w[rd_base | 6'd3]};

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    reject  = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (ifc.start) begin
          if (key_legal(ifc.key_len)) begin
            load    = 1'b1;
            state_d = EXPAND;
          end else begin
            reject  = 1'b1;
          end
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (i_q == t_last) begin
          fin     = 1'b1;
          state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= 2'd0;
      i_q     <= 6'd0;
      j_q     <= 3'd0;
      rcon_q  <= 8'h00;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rk_q    <= '0;
    end else begin
      done_q <= fin;
      err_q  <= reject;
      rk_q   <= (ready_q && ifc.rk_idx <= nr_q) ? rk_word : '0;
      if (load) begin
        len_q   <= ifc.key_len;
        i_q     <= nk_in;
        j_q     <= 3'd0;
        rcon_q  <= 8'h01;
        ready_q <= 1'b0;
      end else if (step) begin
        i_q <= i_q + 6'd1;
        j_q <= j_wrap ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
      end
      if (fin) ready_q <= 1'b1;
    end
  end

  // Word store carries no reset; everything visible is gated by ready.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 8; k++)
        if (6'(k) < nk_in) w[k] <= ifc.key[255 - 32 * k -: 32];
    end else if (step) begin
      w[i_q] <= w_new;
    end
  end

  assign ifc.busy       = (state_q == EXPAND);
  assign ifc.done       = done_q;
  assign ifc.ready      = ready_q;
  assign ifc.err        = err_q;
  assign ifc.num_rounds = ready_q ? nr_q : 4'd0;
  assign ifc.rk         = rk_q;

endmodule
